// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift_sequencer slice and its shift_register benches.
package shift_sequencer_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic state_busy(input state_t s);
        return (s == LOAD) || (s == SHIFT);
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command handshake plus shift_register control pins of the sequencer.
interface shift_sequencer_if
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             CmdValid;
    logic             CmdReady;
    logic [WIDTH-1:0] CmdData;
    logic             CmdDir;
    logic             CmdFill;
    logic [CNT_W-1:0] CmdCount;
    logic             Abort;

    logic             SrEnable;
    logic             SrLoad;
    logic [WIDTH-1:0] SrDataIn;
    logic             SrDirection;
    logic             SrLeftInput;
    logic             SrRightInput;
    logic             Busy;
    logic             Done;

    modport master (
        output CmdValid, CmdData, CmdDir, CmdFill, CmdCount, Abort,
        input  CmdReady, SrEnable, SrLoad, SrDataIn, SrDirection,
               SrLeftInput, SrRightInput, Busy, Done
    );

    modport slave (
        input  CmdValid, CmdData, CmdDir, CmdFill, CmdCount, Abort,
        output CmdReady, SrEnable, SrLoad, SrDataIn, SrDirection,
               SrLeftInput, SrRightInput, Busy, Done
    );

endinterface

// File: rtl/shift_sequencer_counter.sv
// Down-counter tracking the shift cycles still owed in the current sequence.
module shift_counter
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             is_one
);

    logic [CNT_W-1:0] remaining_q;

    // Decrement saturates at zero; the FSM leaves SHIFT at one so zero is never crossed.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
        end else if (load) begin
            remaining_q <= load_value;
        end else if (dec && (remaining_q != '0)) begin
            remaining_q <= remaining_q - CNT_W'(1);
        end
    end

    assign is_one = (remaining_q == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Accepts one command, then drives one load and N shift cycles into shift_register.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    shift_sequencer_if.slave   bus
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic             fill_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_is_one;

    assign accept = (state_q == IDLE) && bus.CmdValid;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command fields stay visible on the register pins until the next accept.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q  <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            data_q  <= bus.CmdData;
            dir_q   <= bus.CmdDir;
            fill_q  <= bus.CmdFill;
            count_q <= bus.CmdCount;
        end
    end

    shift_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (Clock),
        .rst        (Reset),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (count_q),
        .is_one     (cnt_is_one)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        bus.CmdReady = 1'b0;
        bus.SrEnable = 1'b0;
        bus.SrLoad   = 1'b0;
        bus.Done     = 1'b0;
        bus.Busy     = state_busy(state_q);

        case (state_q)
            IDLE: begin
                bus.CmdReady = 1'b1;
                if (bus.CmdValid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.SrEnable = 1'b1;
                bus.SrLoad   = 1'b1;
                cnt_load     = 1'b1;
                if (bus.Abort) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bus.SrEnable = 1'b1;
                cnt_dec      = 1'b1;
                if (bus.Abort) begin
                    state_d = IDLE;
                end else if (cnt_is_one) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.Done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.SrDataIn     = data_q;
    assign bus.SrDirection  = dir_q;
    assign bus.SrLeftInput  = fill_q;
    assign bus.SrRightInput = fill_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a timeline model and an attached shift register model.
module tb_shift_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a command accepted at edge m_acc owns cycle offsets 0 (load),
    // 1..m_n (shift), m_n+1 (done); from m_n+2 on the sequencer is idle again.
    int         edge_n = 0;
    bit         m_act  = 0;
    int         m_acc  = 0;
    int         m_n    = 0;
    logic [3:0] m_data = 4'd0;
    logic       m_dir  = 1'b0;
    logic       m_fill = 1'b0;
    bit         mon_on = 0;

    logic [3:0] q = 4'd0;
    logic       sr_en, sr_ld, sr_dir, sr_l, sr_r;
    logic [3:0] sr_d;

    always @(posedge clk) begin
        int off;
        bit rdy;
        off = edge_n - m_acc;
        rdy = !m_act || (off >= m_n + 2);
        if (rst) begin
            m_act  = 0;
            m_data = 4'd0;
            m_dir  = 1'b0;
            m_fill = 1'b0;
        end else if (m_act && off <= m_n && bus.Abort) begin
            m_act = 0;
        end else if (rdy && bus.CmdValid) begin
            m_act  = 1;
            m_acc  = edge_n + 1;
            m_n    = int'(bus.CmdCount);
            m_data = bus.CmdData;
            m_dir  = bus.CmdDir;
            m_fill = bus.CmdFill;
        end
        edge_n++;
        if (sr_en === 1'b1) begin
            if (sr_ld) q = sr_d;
            else if (sr_dir) q = {q[2:0], sr_r};
            else q = {sr_l, q[3:1]};
        end
    end

    // Per-cycle comparison of every output against the model timeline.
    always @(negedge clk) begin
        int off;
        logic ld, sh, dn;
        logic [11:0] exp_v, act_v;
        sr_en  = bus.SrEnable;
        sr_ld  = bus.SrLoad;
        sr_d   = bus.SrDataIn;
        sr_dir = bus.SrDirection;
        sr_l   = bus.SrLeftInput;
        sr_r   = bus.SrRightInput;
        if (mon_on) begin
            off = edge_n - m_acc;
            ld  = m_act && (off == 0);
            sh  = m_act && (off >= 1) && (off <= m_n);
            dn  = m_act && (off == m_n + 1);
            exp_v = {!(ld | sh | dn), ld | sh, ld, m_data, m_dir, m_fill, m_fill, ld | sh, dn};
            act_v = {bus.CmdReady, bus.SrEnable, bus.SrLoad, bus.SrDataIn, bus.SrDirection,
                     bus.SrLeftInput, bus.SrRightInput, bus.Busy, bus.Done};
            check("cycle_outputs", 32'(act_v), 32'(exp_v));
        end
    end

    int n_load, n_shift, n_done, done_cyc;
    bit saw_dir1;

    always @(negedge clk) begin
        if (bus.SrEnable === 1'b1 && bus.SrLoad === 1'b1) n_load++;
        if (bus.SrEnable === 1'b1 && bus.SrLoad === 1'b0) n_shift++;
        if (bus.Done === 1'b1) begin
            n_done++;
            done_cyc = edge_n + 1;
        end
        if (bus.SrDirection === 1'b1) saw_dir1 = 1;
    end

    task automatic clear_stats();
        n_load   = 0;
        n_shift  = 0;
        n_done   = 0;
        done_cyc = -1000;
        saw_dir1 = 0;
    endtask

    task automatic send(input logic [3:0] d, input logic dir, input logic fill,
                        input logic [2:0] n, input bit hold, output int k);
        bus.CmdValid = 1'b1;
        bus.CmdData  = d;
        bus.CmdDir   = dir;
        bus.CmdFill  = fill;
        bus.CmdCount = n;
        k = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.CmdReady === 1'b1) begin
                @(posedge clk);
                #1;
                k = edge_n;
                break;
            end
        end
        if (!hold) bus.CmdValid = 1'b0;
        check("accept", 32'(k >= 0), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.CmdReady === 1'b1) break;
        end
        check("idle_return", 32'(bus.CmdReady), 32'd1);
    endtask

    initial begin
        int k, k2;
        bus.CmdValid = 1'b0;
        bus.CmdData  = 4'd0;
        bus.CmdDir   = 1'b0;
        bus.CmdFill  = 1'b0;
        bus.CmdCount = 3'd0;
        bus.Abort    = 1'b0;
        clear_stats();

        // Reset values
        @(posedge clk);
        mon_on = 1;
        @(negedge clk);
        check("rst_ready", 32'(bus.CmdReady), 32'd1);
        check("rst_sr_pins", 32'({bus.SrEnable, bus.SrLoad, bus.SrDataIn, bus.SrDirection,
              bus.SrLeftInput, bus.SrRightInput, bus.Busy, bus.Done}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset during the second shift cycle of an N=5 command
        send(4'b1001, 1'b1, 1'b1, 3'd5, 1'b0, k);
        clear_stats();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(bus.CmdReady), 32'd1);
        check("midrst_sr_pins", 32'({bus.SrEnable, bus.SrLoad, bus.SrDataIn, bus.SrDirection,
              bus.SrLeftInput, bus.SrRightInput}), 32'd0);
        repeat (6) @(negedge clk);
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_shifts", 32'(n_shift), 32'd2);

        send(4'b0101, 1'b0, 1'b1, 3'd2, 1'b0, k);
        clear_stats();
        wait_idle();
        check("after_rst_done_cyc", 32'(done_cyc - k), 32'd4);
        check("after_rst_q", 32'(q), 32'b1101);

        // 1010, left, fill 1, N=4
        send(4'b1010, 1'b1, 1'b1, 3'd4, 1'b0, k);
        clear_stats();
        wait_idle();
        check("t2_loads", 32'(n_load), 32'd1);
        check("t2_shifts", 32'(n_shift), 32'd4);
        check("t2_done_cyc", 32'(done_cyc - k), 32'd6);
        check("t2_q", 32'(q), 32'b1111);

        // 0011, right, fill 0, N=4
        send(4'b0011, 1'b0, 1'b0, 3'd4, 1'b0, k);
        clear_stats();
        wait_idle();
        check("t3_q", 32'(q), 32'b0000);
        check("t3_dir_low", 32'(saw_dir1), 32'd0);

        // N=0: load then done
        send(4'b0110, 1'b1, 1'b0, 3'd0, 1'b0, k);
        clear_stats();
        wait_idle();
        check("t4_done_cyc", 32'(done_cyc - k), 32'd2);
        check("t4_shifts", 32'(n_shift), 32'd0);
        check("t4_q", 32'(q), 32'b0110);

        // Abort during the second shift of an N=6 command
        send(4'b1100, 1'b1, 1'b1, 3'd6, 1'b0, k);
        clear_stats();
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.Abort = 1'b1;
        @(posedge clk); #1;
        bus.Abort = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(bus.CmdReady), 32'd1);
        repeat (8) @(negedge clk);
        check("abort_shifts", 32'(n_shift), 32'd2);
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_q", 32'(q), 32'b0011);

        // Valid held with churning data while busy
        send(4'b0101, 1'b0, 1'b1, 3'd2, 1'b1, k);
        bus.CmdCount = 3'd1;
        bus.CmdDir   = 1'b1;
        bus.CmdFill  = 1'b0;
        k2 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) check("held_data", 32'(bus.SrDataIn), 32'b0101);
            if (bus.CmdReady === 1'b1) begin
                bus.CmdData = 4'b1110;
                @(posedge clk);
                #1;
                k2 = edge_n;
                break;
            end
            bus.CmdData = 4'(i * 5 + 3);
        end
        bus.CmdValid = 1'b0;
        clear_stats();
        check("next_accept_edge", 32'(k2 - k), 32'd5);
        @(negedge clk);
        check("second_load", 32'({bus.SrLoad, bus.SrDataIn}), 32'b11110);
        wait_idle();
        check("second_done_cyc", 32'(done_cyc - k2), 32'd3);
        check("second_q", 32'(q), 32'b1100);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d", errors);
        $fatal(1);
    end

endmodule
